// File: rtl/softmax_normalize.sv
// softmax_normalize: divides every Q8.8 lane of the exponent vector by the
// tree sum. One reciprocal 2^24/sum is formed by a 25-step restoring divider,
// then all lanes are multiplied by it in parallel and saturated to 16 bits.
module softmax_normalize #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            valid_in,
  input  logic [DW-1:0]   sum_in,
  input  logic [N*DW-1:0] prop_in_flat,
  output logic            ready_out,
  output logic            valid_out,
  output logic [N*DW-1:0] out_flat,
  output logic            div_zero
);

  localparam int unsigned QW   = 25;        // quotient width: 2^24 / sum
  localparam int unsigned FB   = 16;        // fraction bits of the reciprocal
  localparam int unsigned PW   = DW + QW;   // lane product width
  localparam int unsigned RESW = PW - FB;   // product after dropping FB bits
  localparam logic [4:0]  LAST_STEP = 5'd24;

  typedef enum logic [1:0] {IDLE, DIV, MUL} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [QW-1:0]     quo_q, quo_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic [DW-1:0]     div_q, div_d;
  logic [N*DW-1:0]   prop_q, prop_d;
  logic              zero_q, zero_d;
  logic              valid_q, valid_d;
  logic [N*DW-1:0]   out_q, out_d;
  logic              dz_q, dz_d;

  logic [DW:0]       rem_sh;
  logic              qbit;
  logic [QW-1:0]     recip;
  logic [PW-1:0]     prod;
  logic [RESW-1:0]   res;

  // Next-state: capture, divider step, lane multiply; everything holds when en=0.
  // The quotient register starts as the dividend and shifts quotient bits in
  // at the bottom while dividend bits leave at the top into the remainder.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    prop_d  = prop_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    out_d   = out_q;
    dz_d    = dz_q;
    rem_sh  = '0;
    qbit    = 1'b0;
    recip   = '0;
    prod    = '0;
    res     = '0;
    if (en) begin
      valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid_in) begin
            prop_d  = prop_in_flat;
            div_d   = sum_in;
            zero_d  = (sum_in == '0);
            quo_d   = {1'b1, {(QW-1){1'b0}}};
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
        DIV: begin
          rem_sh = {rem_q, quo_q[QW-1]};
          if (rem_sh >= {1'b0, div_q}) begin
            rem_d = DW'(rem_sh - {1'b0, div_q});
            qbit  = 1'b1;
          end else begin
            rem_d = rem_sh[DW-1:0];
            qbit  = 1'b0;
          end
          quo_d = {quo_q[QW-2:0], qbit};
          cnt_d = 5'(cnt_q + 5'd1);
          if (cnt_q == LAST_STEP) state_d = MUL;
        end
        MUL: begin
          recip = zero_q ? '0 : quo_q;
          for (int unsigned i = 0; i < N; i++) begin
            prod = PW'(prop_q[i*DW +: DW]) * PW'(recip);
            res  = RESW'(prod >> FB);
            out_d[i*DW +: DW] = (res[RESW-1:DW] != '0) ? '1 : res[DW-1:0];
          end
          dz_d    = zero_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      prop_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      prop_q  <= prop_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      dz_q    <= dz_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign valid_out = valid_q;
  assign out_flat  = out_q;
  assign div_zero  = dz_q;

endmodule

// File: doc/softmax_normalize.md
Name: softmax_normalize

Overview:
- Stage directly downstream of add_tree in the Q8.8 softmax datapath.
- Consumes the tree sum (denominator) and the propagated exponent vector (out_prop).
- Computes one reciprocal of the sum with a multi-cycle restoring divider, then multiplies every lane by it in parallel.
- Emits the normalized Q8.8 softmax vector with a one-cycle valid pulse.

Parameters:
- N, 8, number of lanes; must match add_tree N.
- DW, 16, lane and sum width in bits (Q8.8 unsigned).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  global stall; when 0, all state, counters and outputs hold.
- valid_in  input  1  sum_in and prop_in_flat are valid; sampled only when ready_out=1 and en=1.
- sum_in  input  DW  Q8.8 unsigned denominator from add_tree out.
- prop_in_flat  input  N*DW  Q8.8 unsigned numerators from add_tree out_prop; lane i is bits [i*DW +: DW].
- ready_out  output  1  1 when in IDLE; the block accepts a new vector.
- valid_out  output  1  one-cycle pulse; out_flat and div_zero are valid.
- out_flat  output  N*DW  Q8.8 normalized lanes: prop_i / sum.
- div_zero  output  1  the captured sum was 0; qualified by valid_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ready_out=1; valid_out=0; out_flat=0; div_zero=0.
  - Divider registers, iteration counter and captured vector are cleared.
  - Reset in any state, including mid-DIV, aborts the operation; no valid_out follows.
- FSM states: IDLE, DIV, MUL.
- IDLE:
  - ready_out=1; valid_out=0 except during the single pulse cycle after MUL.
  - On an edge with en=1 and valid_in=1: capture sum_in and prop_in_flat; load dividend 2^24 (25 bits) with divisor = sum; clear the counter; go to DIV.
- DIV:
  - ready_out=0.
  - One restoring-division step per enabled edge.
  - 25 steps produce a 25-bit quotient recip = floor(2^24 / sum); recip is 1/sum with 16 fraction bits.
  - After the 25th step, go to MUL.
  - If sum==0: steps still run (fixed latency); the quotient is forced to 0 and a zero flag is set.
- MUL:
  - For each lane: p_i = prop_i * recip (41 bits); r_i = p_i >> 16 (truncate).
  - out_i = 16'hFFFF if r_i > 16'hFFFF, else r_i[15:0].
  - If the zero flag is set: all out_i = 0 and div_zero=1; otherwise div_zero=0.
  - Register out_flat; valid_out=1 for the following cycle; go to IDLE.
- Latency: capture edge E0, last DIV step at E25, outputs registered at E26; valid_out high between E26 and E27.
- out_flat and div_zero hold their values until the next MUL or reset.
- Throughput: the earliest next capture is E27 (ready_out=1 from E26).
- valid_in while ready_out=0 is ignored (dropped, no queueing); upstream must respect ready_out.
- Stall (en=0):
  - Freezes state, counter, partial remainder, quotient, valid_out and out_flat exactly.
  - Latency extends by the number of stalled cycles.
  - A valid_out pulse frozen by en=0 stays high until the next enabled edge.
- valid_in and en both high in IDLE on the same edge as the reset release: the sample is not captured; the reset edge dominates.
- The captured vector is registered at E0; input changes after capture have no effect on the result.

Test Plan:
- Nominal:
  - Stimulus: lanes 0x0100,0x0200,…,0x0800; sum 0x2400.
  - Required: recip=1820; out0=0x0007, out1=0x000E, out7=0x0038; div_zero=0; valid_out exactly one cycle, 27 cycles after capture.
- Unity:
  - Stimulus: sum 0x0100; lane0 0x0100, others 0.
  - Required: recip=65536; out0=0x0100, others 0x0000.
- Zero sum:
  - Stimulus: sum 0x0000, arbitrary lanes.
  - Required: all out lanes 0x0000; div_zero=1 with valid_out; same 27-cycle latency.
- Saturation:
  - Stimulus: sum 0x0001, lane0 0xFFFF, lane1 0x0001.
  - Required: out0=0xFFFF, out1=0x0100.
- Handshake/stall:
  - Second valid_in pulsed during DIV is ignored (only one valid_out).
  - Holding en=0 for 5 cycles mid-DIV delays valid_out by exactly 5 cycles with an unchanged result.
  - A back-to-back vector presented at E27 is accepted.
- Reset mid-op:
  - Stimulus: assert rst=0 asynchronously 10 cycles into DIV.
  - Required: immediately ready_out=1, valid_out=0, out_flat=0; no stale pulse; a fresh nominal vector afterwards yields the nominal results.
